// File: rtl/vga_pkg.sv
// Shared VGA definitions: mode encodings, 640x480@60 timing defaults and
// helpers that derive the total line/frame lengths.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_MEM   = 2'b00,
      MODE_BARS  = 2'b01,
      MODE_CHECK = 2'b10,
      MODE_FILL  = 2'b11
   } mode_e;

   // Counter width; matches the 10-bit h_addr/v_addr outputs.
   localparam int CNT_W = 10;

   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with active-area and sync decode.
// Sync flags are active-high here; pin polarity is applied by the user.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             h_act,
   output logic             act,
   output logic             hsync_on,
   output logic             vsync_on,
   output logic             line_end,
   output logic             frame_end
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_end) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      line_end  = (h_cnt == H_LAST);
      frame_end = line_end && (v_cnt == V_LAST);
      h_act     = (h_cnt < H_ACT);
      act       = h_act && (v_cnt < V_ACT);
      hsync_on  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vsync_on  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   end

endmodule

// File: rtl/vga_stream_ctrl.sv
// Frame-buffer streaming VGA controller: linear read addressing, pattern
// modes, and realignment of sync/blank/colour to the returned memory data.
module vga_stream_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = VGA640_H_ACTIVE,
   parameter int H_FP       = VGA640_H_FP,
   parameter int H_SYNC     = VGA640_H_SYNC,
   parameter int H_BP       = VGA640_H_BP,
   parameter int V_ACTIVE   = VGA640_V_ACTIVE,
   parameter int V_FP       = VGA640_V_FP,
   parameter int V_SYNC     = VGA640_V_SYNC,
   parameter int V_BP       = VGA640_V_BP,
   parameter int HSYNC_POL  = 0,
   parameter int VSYNC_POL  = 0,
   parameter int RD_LAT     = 1,
   parameter int COLOR_W    = 8,
   parameter int ADDR_W     = 19,
   parameter int CHECK_LOG2 = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic [3*COLOR_W-1:0] fill_rgb,
   output logic                 rd_en,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [3*COLOR_W-1:0] rd_data,
   output logic [9:0]           h_addr,
   output logic [9:0]           v_addr,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 valid,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 frame_start,
   output logic                 line_start
);

   localparam int   RGB_W  = 3 * COLOR_W;
   localparam int   BAR_W  = H_ACTIVE / 8;
   localparam int   BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic HS_ON  = HSYNC_POL[0];
   localparam logic VS_ON  = VSYNC_POL[0];

   typedef struct packed {
      logic             act;
      logic             hs;
      logic             vs;
      logic             is_mem;
      logic [9:0]       h;
      logic [9:0]       v;
      logic [RGB_W-1:0] pat;
   } stage_t;

   logic [CNT_W-1:0]  h_cnt, v_cnt;
   logic              h_act, act, hsync_on, vsync_on, line_end, frame_end;
   mode_e             mode_q;
   logic [RGB_W-1:0]  fill_q;
   logic [BAR_CW-1:0] bar_pix;
   logic [2:0]        bar_idx;
   logic [RGB_W-1:0]  pat_rgb;
   stage_t            fetch_s, late_s;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk      (clk),
      .rst      (rst),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .h_act    (h_act),
      .act      (act),
      .hsync_on (hsync_on),
      .vsync_on (vsync_on),
      .line_end (line_end),
      .frame_end(frame_end)
   );

   assign rd_en = act;

   // Address and mode/fill registers all turn over together on the last
   // fetch cycle of the frame, so a frame never mixes two modes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr <= '0;
         mode_q  <= MODE_MEM;
         fill_q  <= '0;
      end else if (frame_end) begin
         rd_addr <= '0;
         mode_q  <= mode_e'(mode);
         fill_q  <= fill_rgb;
      end else if (act) begin
         rd_addr <= rd_addr + ADDR_W'(1);
      end
   end

   // Bar index follows h_cnt without a divider: count pixels within a bar.
   always_ff @(posedge clk) begin
      if (rst || line_end) begin
         bar_pix <= '0;
         bar_idx <= '0;
      end else if (h_act) begin
         if (bar_pix == BAR_CW'(BAR_W - 1)) begin
            bar_pix <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_pix <= bar_pix + BAR_CW'(1);
         end
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves pat_rgb unassigned (no latch).
      pat_rgb = '0;
      case (mode_q)
         MODE_BARS:  pat_rgb = {{COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[0]}}};
         MODE_CHECK: pat_rgb = {RGB_W{h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]}};
         MODE_FILL:  pat_rgb = fill_q;
         default:    pat_rgb = '0;
      endcase
   end

   always_comb begin
      fetch_s        = '0;
      fetch_s.act    = act;
      fetch_s.hs     = hsync_on;
      fetch_s.vs     = vsync_on;
      fetch_s.is_mem = (mode_q == MODE_MEM);
      fetch_s.h      = h_cnt;
      fetch_s.v      = v_cnt;
      fetch_s.pat    = pat_rgb;
   end

   generate
      if (RD_LAT == 0) begin : g_no_dly
         assign late_s = fetch_s;
      end else begin : g_dly
         stage_t dly [RD_LAT];

         // NOTE: the delay line is reset as well, so no stale pixel is marked valid after reset.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < RD_LAT; i++) dly[i] <= '0;
            end else begin
               dly[0] <= fetch_s;
               for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
            end
         end

         assign late_s = dly[RD_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync                 <= ~HS_ON;
         vsync                 <= ~VS_ON;
         valid                 <= 1'b0;
         {vga_r, vga_g, vga_b} <= '0;
         h_addr                <= '0;
         v_addr                <= '0;
         frame_start           <= 1'b0;
         line_start            <= 1'b0;
      end else begin
         hsync                 <= late_s.hs ? HS_ON : ~HS_ON;
         vsync                 <= late_s.vs ? VS_ON : ~VS_ON;
         valid                 <= late_s.act;
         {vga_r, vga_g, vga_b} <= !late_s.act  ? '0 :
                                  late_s.is_mem ? rd_data : late_s.pat;
         h_addr                <= late_s.h;
         v_addr                <= late_s.v;
         frame_start           <= late_s.act && (late_s.h == '0) && (late_s.v == '0);
         line_start            <= late_s.act && (late_s.h == '0);
      end
   end

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// Self-checking bench: two controllers (sync active-low and active-high) run
// off shared stimulus and are compared every cycle against a raster model.
module tb_vga_stream_ctrl;

   localparam int AW    = 19;
   localparam int HA    = 8;
   localparam int HT    = 14;
   localparam int VA    = 4;
   localparam int VT    = 7;
   localparam int FRAME = HT * VT;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [23:0] fill_rgb;

   logic          rd_en_a, rd_en_b;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic [23:0]   rd_data_a, rd_data_b;
   logic [9:0]    h_a, v_a, h_b, v_b;
   logic          hs_a, vs_a, val_a, fs_a, ls_a;
   logic          hs_b, vs_b, val_b, fs_b, ls_b;
   logic [7:0]    r_a, g_a, b_a, r_b, g_b, b_b;

   int          vecs, errs, cyc, fs_cnt, ls_cnt;
   logic [1:0]  m_mode;
   logic [23:0] m_fill;
   logic [1:0]  hist_mode [4];
   logic [23:0] hist_fill [4];

   always #5 clk = ~clk;

   // Synchronous frame buffers that return the address as the pixel value.
   always @(posedge clk) begin
      rd_data_a <= 24'(rd_addr_a);
      rd_data_b <= 24'(rd_addr_b);
   end

   vga_stream_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(0), .VSYNC_POL(0), .RD_LAT(1), .COLOR_W(8),
      .ADDR_W(AW), .CHECK_LOG2(1)
   ) dut_a (
      .clk(clk), .rst(rst), .mode(mode), .fill_rgb(fill_rgb),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .h_addr(h_a), .v_addr(v_a), .hsync(hs_a), .vsync(vs_a), .valid(val_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
      .frame_start(fs_a), .line_start(ls_a)
   );

   vga_stream_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1), .VSYNC_POL(1), .RD_LAT(1), .COLOR_W(8),
      .ADDR_W(AW), .CHECK_LOG2(1)
   ) dut_b (
      .clk(clk), .rst(rst), .mode(mode), .fill_rgb(fill_rgb),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .h_addr(h_b), .v_addr(v_b), .hsync(hs_b), .vsync(vs_b), .valid(val_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
      .frame_start(fs_b), .line_start(ls_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Expected pixel colour from its raster position and the frame's mode.
   function automatic logic [23:0] pix(input int h, input int v, input logic [1:0] m, input logic [23:0] f);
      case (m)
         2'b00:   return 24'(v * HA + h);
         2'b01:   return {(h < 4) ? 8'hFF : 8'h00,
                          ((h % 4) < 2) ? 8'hFF : 8'h00,
                          ((h % 2) == 0) ? 8'hFF : 8'h00};
         2'b10:   return ((((h / 2) + (v / 2)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
         default: return f;
      endcase
   endfunction

   task automatic compare();
      int q, h, v, p, ph, pv, e_addr;
      logic e_val, e_hs, e_vs, e_fs, e_ls;
      logic [23:0] e_rgb;
      q = cyc % FRAME;
      h = q % HT;
      v = q / HT;
      e_addr = (v < VA) ? v * HA + ((h < HA) ? h : HA) : VA * HA;
      check("rd_en_a",   32'(rd_en_a),   32'(h < HA && v < VA));
      check("rd_addr_a", 32'(rd_addr_a), e_addr);
      check("rd_en_b",   32'(rd_en_b),   32'(h < HA && v < VA));
      check("rd_addr_b", 32'(rd_addr_b), e_addr);

      e_val = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = '0; ph = 0; pv = 0;
      if (cyc >= LAT) begin
         p  = (cyc - LAT) % FRAME;
         ph = p % HT;
         pv = p / HT;
         e_val = (ph < HA) && (pv < VA);
         e_hs  = (ph >= HA + 2) && (ph < HA + 4);
         e_vs  = (pv == VA + 1);
         if (e_val) e_rgb = pix(ph, pv, hist_mode[(cyc - LAT) % 4], hist_fill[(cyc - LAT) % 4]);
      end
      e_fs = e_val && ph == 0 && pv == 0;
      e_ls = e_val && ph == 0;

      check("valid_a", 32'(val_a), 32'(e_val));
      check("hsync_a", 32'(hs_a),  32'(!e_hs));
      check("vsync_a", 32'(vs_a),  32'(!e_vs));
      check("rgb_a",   32'({r_a, g_a, b_a}), 32'(e_rgb));
      check("fs_a",    32'(fs_a),  32'(e_fs));
      check("ls_a",    32'(ls_a),  32'(e_ls));
      check("valid_b", 32'(val_b), 32'(e_val));
      check("hsync_b", 32'(hs_b),  32'(e_hs));
      check("vsync_b", 32'(vs_b),  32'(e_vs));
      check("rgb_b",   32'({r_b, g_b, b_b}), 32'(e_rgb));
      check("fs_b",    32'(fs_b),  32'(e_fs));
      check("ls_b",    32'(ls_b),  32'(e_ls));
      if (e_val) begin
         check("h_addr_a", 32'(h_a), ph);
         check("v_addr_a", 32'(v_a), pv);
         check("h_addr_b", 32'(h_b), ph);
         check("v_addr_b", 32'(v_b), pv);
      end
      if (fs_a) fs_cnt++;
      if (ls_a) ls_cnt++;
   endtask

   // One clock: advance the model using the inputs seen at the edge, then check.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         cyc    = 0;
         m_mode = 2'b00;
         m_fill = 24'h0;
      end else begin
         if (cyc % FRAME == FRAME - 1) begin
            m_mode = mode;
            m_fill = fill_rgb;
         end
         cyc++;
      end
      hist_mode[cyc % 4] = m_mode;
      hist_fill[cyc % 4] = m_fill;
      #1;
      compare();
   endtask

   initial begin
      vecs = 0; errs = 0; cyc = 0; fs_cnt = 0; ls_cnt = 0;
      m_mode = 2'b00; m_fill = 24'h0;
      rst = 1'b1; mode = 2'b00; fill_rgb = 24'h0;

      // Reset for three cycles, then two memory-mode frames.
      repeat (3) tick();
      rst = 1'b0;
      fs_cnt = 0; ls_cnt = 0;
      repeat (2 * FRAME) tick();
      check("frame_start_count", fs_cnt, 2);
      check("line_start_count",  ls_cnt, 8);

      // Colour bars requested mid-frame: applies only from the next frame.
      repeat (40) tick();
      mode = 2'b01;
      repeat (2 * FRAME) tick();

      // Solid fill, then checkerboard.
      mode = 2'b11; fill_rgb = 24'h123456;
      repeat (2 * FRAME) tick();
      mode = 2'b10;
      repeat (2 * FRAME) tick();

      // Single-cycle reset at cycle 50 of a frame.
      for (int i = 0; i < FRAME && (cyc % FRAME) != 50; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2 * FRAME) tick();

      // Randomized mode/fill changes with occasional resets.
      for (int k = 0; k < 40; k++) begin
         mode     = 2'($urandom_range(0, 3));
         fill_rgb = 24'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         repeat ($urandom_range(10, 80)) tick();
      end
      repeat (FRAME) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/vga_stream_ctrl.md
Name: vga_stream_ctrl

Overview:
- Parametrised successor to the fixed-640x480 VGA controller/vmem pair: full timing set, sync polarity and memory read latency are parameters.
- Generates the pixel-clock timing and drives linear read addresses into a synchronous (or combinational) frame buffer.
- Realigns sync, blank and colour outputs to the returned memory data.
- Adds registered built-in test-pattern modes and frame/line markers. Sits between the frame-buffer memory and the VGA pins in top.

Parameters:
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active low)
VSYNC_POL, 0, asserted level of vsync
RD_LAT, 1, clk cycles from rd_addr to rd_data (0 = combinational memory)
COLOR_W, 8, bits per colour channel
ADDR_W, 19, rd_addr width (>= clog2(H_ACTIVE*V_ACTIVE))
CHECK_LOG2, 5, log2 of checkerboard square size

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
mode  in  2  00 memory, 01 colour bars, 10 checkerboard, 11 solid fill
fill_rgb  in  3*COLOR_W  solid-fill colour {R,G,B}
rd_en  out  1  frame-buffer read strobe
rd_addr  out  ADDR_W  linear pixel address, v*H_ACTIVE+h
rd_data  in  3*COLOR_W  {R,G,B}, valid RD_LAT cycles after rd_addr
h_addr  out  10  column of the pixel currently on the outputs
v_addr  out  10  row of the pixel currently on the outputs
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
valid  out  1  active video (drives VGA_BLANK_N)
vga_r  out  COLOR_W  red
vga_g  out  COLOR_W  green
vga_b  out  COLOR_W  blue
frame_start  out  1  one-cycle pulse with pixel (0,0) on the outputs
line_start  out  1  one-cycle pulse with pixel (0,v) on the outputs, for every active line

Behaviour:
- Derived totals: H_TOTAL = sum of the four H params; V_TOTAL likewise.
- Counter order is active, FP, sync, BP.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
- Fetch stage (cycle t, combinational from the counters):
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - rd_en = act.
  - rd_addr comes from an incrementing register (no multiplier). It is 0 at frame start, increments after each act cycle, and holds otherwise.
  - rd_addr resets to 0 when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
- Alignment: a delay line of depth RD_LAT carries act, raw hsync/vsync, h_cnt, v_cnt and the pattern colour.
- Output registers capture at t+RD_LAT. All outputs therefore lag the counters by L = RD_LAT+1 cycles, and all outputs are mutually aligned.
- Sync: hsync asserted (= HSYNC_POL) while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, otherwise ~HSYNC_POL. vsync follows the same rule on v_cnt.
- Colour when valid = 0: rgb = 0.
- Colour when valid = 1, by mode:
  - 00 memory: rgb = rd_data.
  - 01 colour bars: bar index b = h / (H_ACTIVE/8), tracked by a bar counter. R = full if !b[2], G = full if !b[1], B = full if !b[0]. Bar 0 is white, bar 7 is black.
  - 10 checkerboard: all-ones when h[CHECK_LOG2]^v[CHECK_LOG2], else 0.
  - 11 solid fill: fill_rgb.
  - "full" means all-ones.
- mode and fill_rgb are sampled into internal registers only on the last fetch cycle of a frame (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1). A change applies from the next frame's pixel (0,0), so a frame never changes mode part-way.
- h_addr/v_addr are the delayed counters. Their values are don't-care (but deterministic) outside active video.
- Reset:
  - Counters, rd_addr and all delay stages are cleared. The mode register is set to 00 and the fill register to 0.
  - Outputs: rd_en = 1 (counters at 0,0 is active) and rd_addr = 0; hsync = ~HSYNC_POL, vsync = ~VSYNC_POL; valid = 0, rgb = 0, frame_start = 0, line_start = 0.
  - A delayed stage carries valid = 0, so no stale pixel appears during the first L cycles after reset.
- Reset mid-frame: on the next cycle the state is identical to the post-reset state. There is no partial-frame recovery.
- Simultaneous wrap: an h and v wrap in the same cycle produces (0,0), rd_addr = 0 and a mode update, all in that one cycle.

Decomposition:
- Shared package vga_pkg: mode encodings (MODE_MEM, MODE_BARS, MODE_CHECK, MODE_FILL), 640x480@60 timing constants, and the H_TOTAL/V_TOTAL helper functions.
- One natural sub-module: vga_timing (the h/v counters, raw sync and act generation). It is reusable by the ps2/text-overlay blocks.
- Delay line, pattern generator and output registers stay in vga_stream_ctrl.

Test Plan:
Bench parameters for all scenarios: H = 8/2/2/2 (H_TOTAL 14), V = 4/1/1/1 (V_TOTAL 7), RD_LAT = 1, so L = 2 and a frame is 98 cycles. The memory model returns rd_data = rd_addr.
1. rst 3 cycles, then release:
   - Cycle 0: rd_en = 1, rd_addr = 0.
   - valid first high at cycle 2 with rgb = 0.
   - hsync low during cycles 12-13 of each line; vsync low for 14 cycles starting at cycle 2+14*5.
2. Memory mode, 2 frames:
   - valid pixels carry rgb values 0..31 in raster order; rd_addr returns to 0 at cycle 98.
   - frame_start pulses exactly at cycles 2 and 100; line_start pulses 4 times per frame.
3. mode = 01 applied at cycle 40:
   - Frame 1 stays memory data.
   - Frame 2 pixel h = 0..7 shows white, yellow, magenta, red, cyan, green, blue, black (bar width 1).
4. mode = 11, fill_rgb = 0x123456, plus a mode = 10 check with CHECK_LOG2 = 1:
   - Fill: every valid pixel of the next frame equals 0x123456.
   - Checkerboard: pixel (2,0) is all-ones and pixel (0,0) is 0.
5. rst pulsed 1 cycle at cycle 50:
   - Next cycle: counters 0, valid = 0, hsync and vsync deasserted, mode register = 00.
   - valid returns 2 cycles later with rgb = 0 (address 0).
6. HSYNC_POL = 1, VSYNC_POL = 1: the sync outputs are inverted relative to scenario 1, and all other outputs are identical.
